led_blink_scheduler: RTL and testbench



---
 rtl/led_sched_pkg.sv | 29 ++
 rtl/led_rr_arb.sv | 45 ++++
 rtl/led_blink_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_sched_pkg
// Shared types and helpers for the LED blink scheduler and its round-robin
// arbiter.
//   led_state_e : burst sequencer states (IDLE, ON, OFF, GAP)
//   BLINK_W     : width of one requester's blink-count slice
//   blink_norm  : maps a requested blink count of 0 to 1
// -----------------------------------------------------------------------------
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

  localparam int BLINK_W = 4;

  // A zero-blink request still earns one blink so the owner always sees done.
  function automatic logic [BLINK_W-1:0] blink_norm(input logic [BLINK_W-1:0] b);
    if (b == {BLINK_W{1'b0}}) begin
      return {{(BLINK_W-1){1'b0}}, 1'b1};
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/led_rr_arb.sv
// -----------------------------------------------------------------------------
// led_rr_arb
// Combinational round-robin pick. Searches req upward starting at ptr+1,
// wrapping past N_REQ-1 back to 0, and reports the first set bit.
//   req    in  N_REQ  request vector
//   ptr    in  IDX_W  index of the last winner (highest-priority slot is ptr+1)
//   winner out IDX_W  selected requester index (0 when valid is low)
//   valid  out 1      at least one request is pending
// -----------------------------------------------------------------------------
module led_rr_arb
  import led_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // ptr never exceeds N_REQ-1, so ptr+k (k<=N_REQ) needs at most one wrap.
  function automatic int wrap_idx(input int v);
    if (v >= N_REQ) begin
      return v - N_REQ;
    end else begin
      return v;
    end
  endfunction

  // First pending request after ptr in circular order; later hits are ignored.
  always_comb begin
    winner = {IDX_W{1'b0}};
    valid  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!valid && req[wrap_idx(int'(ptr) + k)]) begin
        valid  = 1'b1;
        winner = IDX_W'(wrap_idx(int'(ptr) + k));
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// -----------------------------------------------------------------------------
// led_blink_scheduler
// Shares one LED between N_REQ requesters. A round-robin arbiter grants the LED
// to one requester, which then gets its burst of blinks: ON_CYC cycles lit,
// OFF_CYC cycles dark per blink, then GAP_CYC dark cycles before the next grant.
// A single counter times every phase.
//   clk    in  1            system clock
//   rst    in  1            asynchronous reset, active-low
//   req    in  N_REQ        level request per requester
//   blinks in  4*N_REQ      blink count per requester (latched at grant)
//   grant  out N_REQ        one-hot current owner, zero when idle
//   done   out N_REQ        one-cycle pulse on the owner's bit at burst end
//   busy   out 1            high whenever the sequencer is not idle
//   led    out 1            registered LED drive, active-high
// Build option: define LED_SCHED_ABORT_EN to abort a burst (jump to GAP) when
// the owner drops its request during ON or OFF.
// -----------------------------------------------------------------------------
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ON_CYC  = 13500000,
  parameter int OFF_CYC = 13500000,
  parameter int GAP_CYC = 27000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [BLINK_W*N_REQ-1:0] blinks,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     led
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int MAX_AB  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  led_state_e           state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [BLINK_W-1:0]   rem_r, rem_s;
  logic [IDX_W-1:0]     ptr_r, ptr_s;
  logic [N_REQ-1:0]     grant_r, grant_s;
  logic [N_REQ-1:0]     done_r, done_s;
  logic                 busy_r, busy_s;
  logic                 led_r, led_s;

  logic [IDX_W-1:0]     win_s;
  logic                 win_valid_s;
  logic [N_REQ-1:0]     win_onehot_s;
  logic                 abort_s;

  led_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  assign win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;

`ifdef LED_SCHED_ABORT_EN
  // Owner index is the pointer: it is loaded with the winner at grant.
  assign abort_s = ~req[ptr_r];
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rem_s   = rem_r;
    ptr_s   = ptr_r;
    grant_s = grant_r;
    done_s  = {N_REQ{1'b0}};
    led_s   = led_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          grant_s = win_onehot_s;
          ptr_s   = win_s;
          rem_s   = blink_norm(blinks[win_s*BLINK_W +: BLINK_W]);
          cnt_s   = {CNT_W{1'b0}};
          state_s = ON;
          led_s   = 1'b1;
        end else begin
          grant_s = {N_REQ{1'b0}};
          led_s   = 1'b0;
        end
      end
      ON: begin
        if (abort_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = GAP;
          led_s   = 1'b0;
        end else if (cnt_r == ON_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = OFF;
          led_s   = 1'b0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          led_s   = 1'b1;
        end
      end
      OFF: begin
        led_s = 1'b0;
        if (abort_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = GAP;
        end else if (cnt_r == OFF_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          rem_s = rem_r - BLINK_W'(1);
          // Checking for 1 before decrementing keeps rem from wrapping.
          if (rem_r == BLINK_W'(1)) begin
            state_s = GAP;
          end else begin
            state_s = ON;
            led_s   = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        led_s = 1'b0;
        if (cnt_r == GAP_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          done_s  = grant_r;
          grant_s = {N_REQ{1'b0}};
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        rem_s   = {BLINK_W{1'b0}};
        grant_s = {N_REQ{1'b0}};
        led_s   = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // Sequencer state and registered outputs; reset clears the LED immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      rem_r   <= {BLINK_W{1'b0}};
      ptr_r   <= PTR_INIT;
      grant_r <= {N_REQ{1'b0}};
      done_r  <= {N_REQ{1'b0}};
      busy_r  <= 1'b0;
      led_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      ptr_r   <= ptr_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      led_r   <= led_s;
    end
  end

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign led   = led_r;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// -----------------------------------------------------------------------------
// tb_led_blink_scheduler
// Directed bench for led_blink_scheduler (N_REQ=4, ON=4, OFF=3, GAP=2).
// A burst-level model (grant time + offset arithmetic) predicts every output
// each cycle; directed tests add hand-computed literal expectations.
// Honours LED_SCHED_ABORT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_led_blink_scheduler;

  localparam int N   = 4;
  localparam int ONC = 4;
  localparam int OFC = 3;
  localparam int GPC = 2;
  localparam int PER = ONC + OFC;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] blinks;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  int total = 0;
  int bad   = 0;

  led_blink_scheduler #(
    .N_REQ   (N),
    .ON_CYC  (ONC),
    .OFF_CYC (OFC),
    .GAP_CYC (GPC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .blinks (blinks),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- burst-level model ----------------
  typedef struct {
    bit         active;
    int         owner;
    int         t;      // cycles since the first lit cycle of the burst
    int         n;      // blinks in this burst
    int         ptr;    // last granted requester
    logic [3:0] dn;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t x;
    x.active = 1'b0; x.owner = 0; x.t = 0; x.n = 0; x.ptr = N - 1; x.dn = 4'b0000;
    return x;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input logic [3:0] r, input logic [15:0] b);
    mdl_t x;
    bit   found;
    int   j;
    int   cntb;
    x = c;
    x.dn = 4'b0000;
    found = 1'b0;
    if (c.active) begin
      x.t = c.t + 1;
`ifdef LED_SCHED_ABORT_EN
      if (c.t < c.n * PER && !r[c.owner]) x.t = c.n * PER;
`endif
      if (x.t == c.n * PER + GPC) begin
        x.active = 1'b0;
        x.dn[c.owner] = 1'b1;
      end
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= N; k++) begin
        j = (c.ptr + k) % N;
        if (!found && r[j]) begin
          found = 1'b1;
          cntb = int'(b[j*4 +: 4]);
          x.active = 1'b1; x.owner = j; x.ptr = j; x.t = 0;
          x.n = (cntb == 0) ? 1 : cntb;
        end
      end
    end
    return x;
  endfunction

  // Model advances on the same edges the design samples.
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= mreset();
    else      m <= mstep(m, req, blinks);
  end

  logic       exp_led;
  logic [3:0] exp_grant;
  assign exp_led   = m.active && (m.t < m.n * PER) && ((m.t % PER) < ONC);
  assign exp_grant = m.active ? (4'b0001 << m.owner) : 4'b0000;

  // ---------------- per-cycle compare and monitors ----------------
  int   gq[$];
  logic [3:0] prev_g = 4'b0000;
  int   led_hi = 0;
  int   done_cnt = 0;
  logic [3:0] done_acc = 4'b0000;

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("led", led, exp_led);
      chk("grant", grant, exp_grant);
      chk("busy", busy, m.active);
      chk("done", done, m.dn);
      if (grant != 4'b0000 && grant != prev_g) gq.push_back(oh_idx(grant));
      prev_g = grant;
      if (led) led_hi++;
      if (done != 4'b0000) done_cnt++;
      done_acc = done_acc | done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'b0000;
    step(); step();
    rst = 1'b1;
    gq.delete(); led_hi = 0; done_cnt = 0; done_acc = 4'b0000;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_grants(input string nm, input int cnt);
    int n = 0;
    while (gq.size() < cnt && n < 300) begin step(); n++; end
    chk(nm, (gq.size() >= cnt), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [15:0] pat;

  initial begin
    rst = 1'b0; req = 4'b0000; blinks = 16'h0000;
    step(); step();
    chk("rst_led", led, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'b0000);
    rst = 1'b1;
    step();

    // T1: two blinks for requester 0, literal LED pattern and done on cycle 17
    pat = 16'b1111_0001_1110_0000;
    blinks = 16'h0002; req = 4'b0001;
    for (int s = 1; s <= 17; s++) begin
      step();
      if (s == 1) req = 4'b0000;
      if (s <= 16) begin
        chk("t1_led", led, pat[16-s]);
        chk("t1_grant", grant, 4'b0001);
      end else begin
        chk("t1_done", done, 4'b0001);
        chk("t1_busy_after", busy, 1'b0);
      end
    end
    step();

    // T2: 0 and 2 together from reset, served 0 then 2
    do_reset();
    blinks = 16'h0101; req = 4'b0101;
    wait_grants("t2_wait", 2);
    req = 4'b0000;
    wait_idle("t2_idle");
    step();
    chk("t2_ngrants", gq.size(), 2);
    chk("t2_first", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("t2_second", (gq.size() > 1) ? gq[1] : -1, 2);
    chk("t2_dones", done_cnt, 2);
    chk("t2_done_bits", done_acc, 4'b0101);

    // T3: all four held, one blink each, order 0,1,2,3,0
    do_reset();
    blinks = 16'h1111; req = 4'b1111;
    wait_grants("t3_wait", 5);
    req = 4'b0000;
    wait_idle("t3_idle");
    step();
    chk("t3_ngrants", gq.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t3_order", (gq.size() > i) ? gq[i] : -1, i % 4);

    // T4: blink count 0 behaves as one blink
    gq.delete(); led_hi = 0; done_cnt = 0; done_acc = 4'b0000;
    blinks = 16'h0000; req = 4'b0010;
    step();
    req = 4'b0000;
    wait_idle("t4_idle");
    step();
    chk("t4_led_cycles", led_hi, 4);
    chk("t4_dones", done_cnt, 1);
    chk("t4_done_bit", done_acc, 4'b0010);

    // T5: asynchronous reset in the second ON cycle
    do_reset();
    blinks = 16'h0001; req = 4'b0001;
    step(); step();
    done_cnt = 0;
    #2 rst = 1'b0;
    #1;
    chk("t5_led_async", led, 1'b0);
    chk("t5_grant_async", grant, 4'b0000);
    chk("t5_busy_async", busy, 1'b0);
    step(); step();
    chk("t5_no_done", done, 4'b0000);
    rst = 1'b1;
    led_hi = 0; done_cnt = 0;
    step();
    req = 4'b0000;
    wait_idle("t5_idle");
    step();
    chk("t5_restart_led", led_hi, 4);
    chk("t5_restart_done", done_cnt, 1);

    // T6: five blinks, owner drops req in the second ON cycle
    do_reset();
    blinks = 16'h0005; req = 4'b0001;
    step(); step();
    req = 4'b0000;
    step();
`ifdef LED_SCHED_ABORT_EN
    chk("t6_led_after_drop", led, 1'b0);
`else
    chk("t6_led_after_drop", led, 1'b1);
`endif
    wait_idle("t6_idle");
    step();
`ifdef LED_SCHED_ABORT_EN
    chk("t6_led_cycles", led_hi, 2);
`else
    chk("t6_led_cycles", led_hi, 20);
`endif
    chk("t6_dones", done_cnt, 1);
    chk("t6_done_bit", done_acc, 4'b0001);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
